// File: rtl/usensor_array_if.sv
`default_nettype none
// ============================================================================
//  Module   : usensor_array_if
//  Purpose  : Bundles the control, echo/trigger and result signals of the
//             multi-channel ultrasonic ranger.
//  Ports    : enable, single, start, echo[CHANNELS]       (towards ranger)
//             trig[CHANNELS], distance[CHANNELS*DIST_W],
//             valid, valid_ch, timeout[CHANNELS], busy     (from ranger)
//  Modports : slave  - the ranger controller
//             master - the system / game logic driving it
//  Revision : 1.0  initial release
// ============================================================================
interface usensor_array_if #(
  parameter int CHANNELS = 4,
  parameter int DIST_W   = 9
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                       enable;
  logic                       single;
  logic                       start;
  logic [CHANNELS-1:0]        echo;
  logic [CHANNELS-1:0]        trig;
  logic [CHANNELS*DIST_W-1:0] distance;
  logic                       valid;
  logic [CH_W-1:0]            valid_ch;
  logic [CHANNELS-1:0]        timeout;
  logic                       busy;

  modport slave (
    input  enable, single, start, echo,
    output trig, distance, valid, valid_ch, timeout, busy
  );

  modport master (
    output enable, single, start, echo,
    input  trig, distance, valid, valid_ch, timeout, busy
  );
endinterface
`default_nettype wire

// File: rtl/usensor_array.sv
`default_nettype none
// ============================================================================
//  Module   : usensor_array
//  Purpose  : Round-robin multi-channel ultrasonic ranger. Each slot triggers
//             one sensor, times its echo with a prescaled counter, converts
//             the width to saturated centimetres and applies timeouts.
//  Ports    : clock   - system clock
//             resetn  - asynchronous active-low reset
//             bus     - usensor_array_if.slave (control, echo, trig, results)
//  Revision : 1.0  initial release
// ============================================================================
module usensor_array #(
  parameter int CHANNELS       = 4,
  parameter int DIST_W         = 9,
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2900,
  parameter int TIMEOUT_CYCLES = 1250000,
  parameter int PERIOD_CYCLES  = 3000000
) (
  input  wire logic        clock,
  input  wire logic        resetn,
  usensor_array_if.slave   bus
);

  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SLOT_W = $clog2(PERIOD_CYCLES);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PRE_W  = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

  localparam logic [DIST_W-1:0] DIST_MAX    = '1;
  localparam logic [SLOT_W-1:0] TRIG_LAST   = SLOT_W'(TRIG_CYCLES - 1);
  localparam logic [SLOT_W-1:0] PERIOD_LAST = SLOT_W'(PERIOD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(CYCLES_PER_CM - 1);
  localparam logic [CH_W-1:0]   CH_LAST     = CH_W'(CHANNELS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRIG    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_HOLDOFF = 3'd4;

  logic [2:0]                 state_q,    state_d;
  logic [CH_W-1:0]            ch_q,       ch_d;
  logic [SLOT_W-1:0]          slot_cnt_q, slot_cnt_d;
  logic [TO_W-1:0]            wait_cnt_q, wait_cnt_d;
  logic [TO_W-1:0]            n_q,        n_d;
  logic [PRE_W-1:0]           pre_q,      pre_d;
  logic [DIST_W-1:0]          cm_q,       cm_d;
  logic [CHANNELS*DIST_W-1:0] distance_q, distance_d;
  logic [CHANNELS-1:0]        timeout_q,  timeout_d;
  logic                       valid_q,    valid_d;
  logic [CH_W-1:0]            valid_ch_q, valid_ch_d;

  // Two-flop synchroniser plus one extra stage for edge detection.
  logic [CHANNELS-1:0]        echo_meta_q;
  logic [CHANNELS-1:0]        echo_s_q;
  logic [CHANNELS-1:0]        echo_prev_q;

  logic                       echo_cur;
  logic                       echo_rise;
  logic                       wr_en;
  logic [DIST_W-1:0]          wr_dist;
  logic                       wr_to;
  logic [CHANNELS-1:0]        trig_w;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      echo_meta_q <= '0;
      echo_s_q    <= '0;
      echo_prev_q <= '0;
    end else begin
      echo_meta_q <= bus.echo;
      echo_s_q    <= echo_meta_q;
      echo_prev_q <= echo_s_q;
    end
  end

  assign echo_cur  = echo_s_q[ch_q];
  assign echo_rise = echo_s_q[ch_q] & ~echo_prev_q[ch_q];

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    slot_cnt_d = (state_q == S_IDLE) ? '0 : slot_cnt_q + 1'b1;
    wait_cnt_d = wait_cnt_q;
    n_d        = n_q;
    pre_d      = pre_q;
    cm_d       = cm_q;
    distance_d = distance_q;
    timeout_d  = timeout_q;
    valid_d    = 1'b0;
    valid_ch_d = valid_ch_q;
    wr_en      = 1'b0;
    wr_dist    = DIST_MAX;
    wr_to      = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.enable && (!bus.single || bus.start)) begin
          state_d    = S_TRIG;
          slot_cnt_d = '0;
        end
      end

      S_TRIG: begin
        if (slot_cnt_q == TRIG_LAST) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end

      S_WAIT: begin
        if (echo_rise) begin
          // The rising cycle itself is the first echo-high cycle, so the
          // counters start as if one cycle has already been counted; this
          // keeps the result equal to floor(N / CYCLES_PER_CM).
          state_d = S_MEASURE;
          n_d     = TO_W'(1);
          pre_d   = (CYCLES_PER_CM == 1) ? '0 : PRE_W'(1);
          cm_d    = (CYCLES_PER_CM == 1) ? DIST_W'(1) : '0;
        end else if (wait_cnt_q == TO_LAST) begin
          wr_en   = 1'b1;
          state_d = S_HOLDOFF;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_MEASURE: begin
        if (!echo_cur) begin
          wr_en   = 1'b1;
          wr_dist = cm_q;
          wr_to   = 1'b0;
          state_d = S_HOLDOFF;
        end else if (n_q == TO_LAST) begin
          // This cycle would be echo-high cycle number TIMEOUT_CYCLES.
          wr_en   = 1'b1;
          state_d = S_HOLDOFF;
        end else begin
          n_d = n_q + 1'b1;
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (cm_q != DIST_MAX) begin
              cm_d = cm_q + 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end

      S_HOLDOFF: begin
        if (slot_cnt_q == PERIOD_LAST) begin
          ch_d       = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
          slot_cnt_d = '0;
          if (!bus.single && bus.enable) begin
            state_d = S_TRIG;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (wr_en) begin
      distance_d[int'(ch_q)*DIST_W +: DIST_W] = wr_dist;
      timeout_d[ch_q]                        = wr_to;
      valid_d                                = 1'b1;
      valid_ch_d                             = ch_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      slot_cnt_q <= '0;
      wait_cnt_q <= '0;
      n_q        <= '0;
      pre_q      <= '0;
      cm_q       <= '0;
      distance_q <= '0;
      timeout_q  <= '0;
      valid_q    <= 1'b0;
      valid_ch_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      slot_cnt_q <= slot_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      n_q        <= n_d;
      pre_q      <= pre_d;
      cm_q       <= cm_d;
      distance_q <= distance_d;
      timeout_q  <= timeout_d;
      valid_q    <= valid_d;
      valid_ch_q <= valid_ch_d;
    end
  end

  // Trigger decoded straight from the state register so that an
  // asynchronous reset removes it without waiting for a clock.
  always_comb begin
    trig_w = '0;
    if (state_q == S_TRIG) begin
      trig_w[ch_q] = 1'b1;
    end
  end

  assign bus.trig     = trig_w;
  assign bus.distance = distance_q;
  assign bus.valid    = valid_q;
  assign bus.valid_ch = valid_ch_q;
  assign bus.timeout  = timeout_q;
  assign bus.busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usensor_array.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_usensor_array
//  Purpose  : Randomised scoreboard bench for usensor_array (2 channels).
//  Revision : 1.0  initial release
// ============================================================================
module tb_usensor_array;

  localparam int CH   = 2;
  localparam int DW   = 4;
  localparam int TRIG = 4;
  localparam int CPC  = 10;
  localparam int TO   = 200;
  localparam int PER  = 450;
  localparam int DMAX = (1 << DW) - 1;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  usensor_array_if #(.CHANNELS(CH), .DIST_W(DW)) bus ();

  usensor_array #(
    .CHANNELS(CH), .DIST_W(DW), .TRIG_CYCLES(TRIG),
    .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TO), .PERIOD_CYCLES(PER)
  ) dut (
    .clock (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    int ch;
    int d;
    int to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   seen   = 0;
  int   exp_ch = 0;
  int   cyc    = 0;
  int   m_dist[CH];
  int   m_to[CH];
  bit   prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [CH*DW-1:0] pack_dist();
    logic [CH*DW-1:0] r;
    for (int i = 0; i < CH; i++) r[i*DW +: DW] = DW'(m_dist[i]);
    return r;
  endfunction

  function automatic logic [CH-1:0] pack_to();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (m_to[i] != 0);
    return r;
  endfunction

  // Monitor: every valid pops the oldest expected result.
  exp_t mon_e;
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.valid) begin
        chk("valid_one_cycle", prev_valid, 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: valid_ch=%0d with no result outstanding", bus.valid_ch);
        end else begin
          mon_e = sb.pop_front();
          m_dist[mon_e.ch] = mon_e.d;
          m_to[mon_e.ch]   = mon_e.to;
          chk("valid_ch", bus.valid_ch, mon_e.ch);
          chk("distance_vec", bus.distance, pack_dist());
          chk("timeout_vec", bus.timeout, pack_to());
          seen++;
        end
      end
      prev_valid = bus.valid;
    end
  end

  // mode 0: echo pulse of w cycles after d cycles; 1: no echo; 2: echo held high
  task automatic run_slot(input int mode, input int d, input int w, input bit drop_en,
                          output int rise_cyc);
    int   n;
    int   width;
    int   target;
    exp_t e;
    target   = seen + 1;
    rise_cyc = 0;
    if (mode == 2) bus.echo[exp_ch] = 1'b1;
    n = 0;
    while (bus.trig == '0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (bus.trig == '0) begin
      checks++;
      errors++;
      $display("FAIL trig_wait: no trigger seen, expected channel %0d", exp_ch);
      bus.echo = '0;
      return;
    end
    rise_cyc = cyc;
    chk("trig_channel", bus.trig, 1 << exp_ch);
    chk("busy_in_slot", bus.busy, 1);
    width = 1;
    forever begin
      @(negedge clk);
      if (bus.trig != '0 && width < 100) width++;
      else break;
    end
    chk("trig_width", width, TRIG);

    // Reference: truncated cm, saturated, timeout when no edge or too long.
    e.ch = exp_ch;
    if (mode != 0 || w >= TO) begin
      e.d  = DMAX;
      e.to = 1;
    end else begin
      e.d  = (w / CPC > DMAX) ? DMAX : w / CPC;
      e.to = 0;
    end
    sb.push_back(e);

    if (mode == 0) begin
      repeat (d) @(negedge clk);
      bus.echo[exp_ch] = 1'b1;
      for (int i = 0; i < w; i++) begin
        @(negedge clk);
        if (drop_en && i == w / 2) bus.enable = 1'b0;
      end
      bus.echo[exp_ch] = 1'b0;
    end

    n = 0;
    while (seen < target && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (seen < target) begin
      checks++;
      errors++;
      $display("FAIL result_wait: no valid for channel %0d", exp_ch);
      sb.delete();
    end
    bus.echo[exp_ch] = 1'b0;
    exp_ch = (exp_ch + 1) % CH;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.busy, 0);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.trig != '0 || bus.busy) hits++;
    end
    chk(name, hits, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int r0, r1, r;
    int mode, d, w;
    bus.enable = 1'b0;
    bus.single = 1'b0;
    bus.start  = 1'b0;
    bus.echo   = '0;
    for (int i = 0; i < CH; i++) begin
      m_dist[i] = 0;
      m_to[i]   = 0;
    end

    repeat (3) @(negedge clk);
    chk("reset_trig", bus.trig, 0);
    chk("reset_distance", bus.distance, 0);
    chk("reset_valid", bus.valid, 0);
    chk("reset_valid_ch", bus.valid_ch, 0);
    chk("reset_timeout", bus.timeout, 0);
    chk("reset_busy", bus.busy, 0);
    resetn = 1'b1;

    // Continuous scan with directed boundary widths.
    bus.enable = 1'b1;
    run_slot(0, 20, 47, 1'b0, r0);   // ch0 -> 4 cm
    run_slot(0, 30, 200, 1'b0, r1);  // ch1 -> measure timeout
    chk("slot_period", r1 - r0, PER);
    run_slot(1, 0, 0, 1'b0, r);      // ch0 no echo -> wait timeout
    run_slot(0, 10, 160, 1'b0, r);   // ch1 -> saturated, no timeout
    run_slot(2, 0, 0, 1'b0, r);      // ch0 held high -> timeout
    run_slot(0, 5, 199, 1'b0, r);    // ch1 just under timeout
    run_slot(0, 5, 10, 1'b0, r);     // ch0 exactly 1 cm
    run_slot(0, 5, 9, 1'b0, r);      // ch1 truncates to 0

    for (int k = 0; k < 12; k++) begin
      mode = $urandom_range(0, 9);
      d    = $urandom_range(1, 150);
      w    = $urandom_range(1, 230);
      run_slot((mode == 0) ? 1 : (mode == 1) ? 2 : 0, d, w, 1'b0, r);
    end

    // Drop enable mid-measurement: slot completes, scanning stops.
    run_slot(0, 10, 100, 1'b1, r);
    wait_idle("idle_after_disable");
    expect_quiet("quiet_after_disable", 500);

    // Single-shot mode.
    bus.single = 1'b1;
    bus.enable = 1'b1;
    expect_quiet("single_no_start", 50);
    pulse_start();
    run_slot(0, 8, 73, 1'b0, r);
    chk("busy_before_ignored_start", bus.busy, 1);
    pulse_start();                   // ignored: not in IDLE
    wait_idle("idle_after_single");
    expect_quiet("single_one_slot", 500);
    pulse_start();
    run_slot(0, 12, 131, 1'b0, r);
    wait_idle("idle_after_single2");

    // Reset during TRIG with echo held high across reset.
    bus.single = 1'b0;
    r = 0;
    while (bus.trig == '0 && r < 100) begin
      @(negedge clk);
      r++;
    end
    chk("trig_before_reset", (bus.trig != '0), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_trig", bus.trig, 0);
    chk("async_reset_distance", bus.distance, 0);
    chk("async_reset_timeout", bus.timeout, 0);
    chk("async_reset_busy", bus.busy, 0);
    sb.delete();
    for (int i = 0; i < CH; i++) begin
      m_dist[i] = 0;
      m_to[i]   = 0;
    end
    exp_ch     = 0;
    prev_valid = 1'b0;
    bus.echo[0] = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    run_slot(2, 0, 0, 1'b0, r);      // ch0 held high since reset -> timeout
    run_slot(0, 15, 55, 1'b0, r);    // ch1 -> 5 cm

    bus.enable = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usensor_array.md
Name: usensor_array

Overview:
Multi-channel ultrasonic ranger controller, the parametrised successor of the single-sensor HC-SR04 front end. It time-multiplexes CHANNELS sensors round-robin, one channel per slot. In each slot it issues a trigger pulse, times the echo, converts the echo width to centimetres with a prescaled counter (no divider), saturates, and applies a timeout. Per-channel distances feed the BCD/hex display path and game logic. Modes: continuous scan, or single-shot on request.

Parameters:
CHANNELS, 4, number of sensors (1..8)
DIST_W, 9, distance width in cm per channel
TRIG_CYCLES, 500, trigger high time in clocks (10 us at 50 MHz)
CYCLES_PER_CM, 2900, clocks of echo per cm (58 us at 50 MHz)
TIMEOUT_CYCLES, 1250000, maximum clocks in WAIT_RISE, and separately in MEASURE
PERIOD_CYCLES, 3000000, slot length in clocks from trigger start; must exceed TRIG_CYCLES + 2*TIMEOUT_CYCLES + 4

Ports:
clock  in  1  system clock (CLOCK_50)
resetn  in  1  asynchronous active-low reset
enable  in  1  scanning allowed
single  in  1  1 = single-shot mode, 0 = continuous
start  in  1  single-shot request, 1-cycle pulse, honoured only in IDLE with single=1
echo  in  CHANNELS  raw echo inputs, asynchronous
trig  out  CHANNELS  trigger outputs, at most one bit high
distance  out  CHANNELS*DIST_W  packed cm results, channel i at [i*DIST_W +: DIST_W]
valid  out  1  1-cycle pulse when a channel result updates
valid_ch  out  $clog2(CHANNELS) (min 1)  channel index qualified by valid
timeout  out  CHANNELS  per-channel flag: last measurement timed out
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; ch=0; all counters 0; trig=0, distance=0, valid=0, valid_ch=0, timeout=0, busy=0. Asserting reset mid-slot drops trig immediately.
- Each echo bit passes through a 2-flop synchroniser (echo_s). All decisions use echo_s; both edges are delayed equally.
- IDLE: go to TRIG if enable=1 and either single=0, or single=1 and start=1. Otherwise stay.
- TRIG: trig[ch]=1 for exactly TRIG_CYCLES clocks. slot_cnt starts at 0 on the first TRIG cycle. Then go to WAIT_RISE with wait_cnt=0.
- WAIT_RISE: wait for a 0->1 edge of echo_s[ch]. An echo held high throughout does not count as an edge.
  - On edge: go to MEASURE with pre=0, cm=0, n=0.
  - If wait_cnt reaches TIMEOUT_CYCLES with no edge: timeout path.
- MEASURE: each cycle echo_s[ch]=1, n increments.
  - pre counts 0..CYCLES_PER_CM-1. On wrap, cm increments, saturating at 2^DIST_W-1.
  - First cycle echo_s[ch]=0: write distance[ch]=cm, which equals min(floor(N/CYCLES_PER_CM), 2^DIST_W-1) for N echo-high cycles (truncation, no rounding). Clear timeout[ch]. Go to HOLDOFF.
  - If n reaches TIMEOUT_CYCLES: timeout path.
- Timeout path: distance[ch]=all ones, timeout[ch]=1, go to HOLDOFF.
- valid pulses high for one cycle, with valid_ch=ch, in the cycle after the distance write (both normal and timeout). distance is stable from that cycle on.
- HOLDOFF: wait until slot_cnt == PERIOD_CYCLES-1. This guarantees the sensor re-arm time. Then:
  - ch <= (ch == CHANNELS-1) ? 0 : ch+1;
  - continuous mode with enable=1: go to TRIG;
  - otherwise: go to IDLE.
- Single-shot: one start produces one slot on the current channel, then the scan advances. start during a non-IDLE state is ignored.
- enable takes effect only at slot boundaries; a slot in progress always completes. Changing single mid-slot also acts only at the slot end.
- Only the active channel's distance/timeout change; other channels hold their values.

Test Plan:
Use CHANNELS=2, DIST_W=4, TRIG_CYCLES=4, CYCLES_PER_CM=10, TIMEOUT_CYCLES=200, PERIOD_CYCLES=450.
1. Reset, enable=1, single=0; echo[0] high 47 cycles after 20-cycle delay -> trig[0] high exactly 4 cycles; distance[3:0]=4; timeout[0]=0; valid pulse with valid_ch=0; next trig[1] rises 450 cycles after trig[0] rose.
2. echo[1] high 200 cycles -> n hits timeout: distance[7:4]=15, timeout[1]=1; echo[1] high 160 cycles in a later slot -> distance[7:4]=15 (saturated), timeout[1]=0.
3. echo[0] never rises -> after 200 WAIT_RISE cycles distance[3:0]=15, timeout[0]=1, valid pulses; echo held high from reset also gives timeout.
4. single=1: start pulse in IDLE -> exactly one trig on ch0, one valid, return to IDLE with busy=0; start while busy=1 -> no extra slot; next start uses ch1.
5. enable dropped mid-MEASURE -> current result still written and valid pulses; no further trig; busy=0 after slot end.
6. resetn low mid-TRIG -> trig=0 asynchronously, distance=0; after release with enable=1, scanning restarts at ch0.
